// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative HI/LO mult/div engine with hazard stall; `MULDIV_SIGNED_EN adds signed ops via sgnE.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             multordivE,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgnE,
`endif
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [1:0]       mfhlD,
  output logic             busy,
  output logic             stallhl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             divzero
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [CNTW-1:0] cnt;
  logic op, neg_q, neg_r, sa, sb;
  logic [WIDTH-1:0] opd, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, nxt, res;
  logic [WIDTH:0] sum, diff;
`ifdef MULDIV_SIGNED_EN
  assign sa = sgnE & srcaE[WIDTH-1];
  assign sb = sgnE & srcbE[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign mag_a = sa ? -srcaE : srcaE;
  assign mag_b = sb ? -srcbE : srcbE;
  assign busy = (state == RUN);
  assign stallhl = busy & ((mfhlD != 2'b00) | startE);
  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opd : '0};
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    nxt = op ? (diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
             : {sum, acc[WIDTH-1:1]};
    res = op ? {neg_r ? -nxt[2*WIDTH-1:WIDTH] : nxt[2*WIDTH-1:WIDTH], neg_q ? -nxt[WIDTH-1:0] : nxt[WIDTH-1:0]}
             : (neg_q ? -nxt : nxt);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      divzero <= 1'b0;
      acc <= '0;
      opd <= '0;
      op <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      divzero <= 1'b0;
      if (state == RUN) begin
        acc <= nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CNTW'(WIDTH-1)) begin
          hi <= res[2*WIDTH-1:WIDTH];
          lo <= res[WIDTH-1:0];
          done <= 1'b1;
          state <= FIN;
        end
      end else if (startE) begin
        op <= multordivE;
        cnt <= '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        opd <= multordivE ? mag_b : mag_a;
        acc <= {{WIDTH{1'b0}}, multordivE ? mag_a : mag_b};
        if (multordivE && srcbE == '0) begin
          hi <= srcaE;
          lo <= '1;
          done <= 1'b1;
          divzero <= 1'b1;
          state <= FIN;
        end else begin
          state <= RUN;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide engine and sequencer for the HI/LO resource of the pipelined MIPS datapath. It accepts a mult/div issue from the Execute stage and runs a radix-2 shift-add or restoring-divide loop for WIDTH cycles. It then loads HI/LO. While busy, it raises a stall request to the hazard unit if a dependent mfhi/mflo or a second mult/div reaches the pipeline.

Parameters:
WIDTH, 32, operand/result width; also the iteration count
CNTW, 6, iteration counter width (must satisfy 2^CNTW > WIDTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startE  in  1  mult/div issued in E stage (hlwriteE qualified by ~stall)
multordivE  in  1  0 = mult(u), 1 = div(u)
srcaE  in  WIDTH  multiplicand / dividend
srcbE  in  WIDTH  multiplier / divisor
mfhlD  in  2  HI/LO read in D stage: 00 none, 01 mflo, 10 mfhi, 11 reserved (treated as read)
busy  out  1  iteration loop active
stallhl  out  1  stall request to hazard unit
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
done  out  1  one-cycle pulse: results just loaded
divzero  out  1  one-cycle pulse alongside done for divide by zero

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset. Every output and register updates only on the rising clk edge.
- Reset: state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, divzero=0, stallhl=0. Reset wins over every other input in the same cycle, including a reset that arrives mid-RUN. The operation in flight is discarded and HI/LO are cleared.
- States: IDLE, RUN, FIN.
- IDLE, startE=1 at edge E0: latch the operands and the op, set cnt=0, go to RUN. Any other input in IDLE: stay in IDLE.
- RUN: performs one iteration per edge and increments cnt. On the edge where cnt==WIDTH-1, load hi/lo and go to FIN. Result latency: hi/lo are visible WIDTH cycles after E0.
- FIN: lasts exactly one cycle. done=1, busy=0. Next edge goes to RUN if startE=1, else to IDLE. Back-to-back ops therefore cost WIDTH+1 cycles each.
- Multiply: unsigned 2*WIDTH shift-add. hi = product[2W-1:W], lo = product[W-1:0].
- Divide: unsigned restoring divide. lo = quotient, hi = remainder.
- Divide by zero (srcbE==0 at E0): skip RUN and go to FIN at the next edge. Load hi = dividend, lo = all ones, and pulse divzero=1 together with done.
- busy = (state==RUN). It is a Moore output.
- stallhl = busy & (mfhlD!=00 | startE). It is combinational from the registered state.
  - In FIN, HI/LO are already valid, so no stall is raised.
- startE while busy: ignored by the FSM. The stall holds the instruction in E until FIN, where it is accepted.
- hi/lo hold their value outside the load edge. Partial results are never visible on hi/lo.
- Simultaneous startE and reset: reset wins and the start is dropped.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: adds an input port sgnE (1 bit, 1 = signed mult/div).
  - Operands are converted to magnitudes at E0 and results are sign-corrected when hi/lo are loaded. Latency is unchanged.
  - Quotient sign = sa^sb; remainder takes the dividend's sign.
  - Signed divide by zero behaves as the unsigned case.
- Not defined: no sgnE port; all operations are unsigned.

Test Plan:
- reset=1 two cycles, then release -> hi=0, lo=0, busy=0, stallhl=0, done=0.
- mult 7*6 -> busy=1 for 32 cycles; done pulses with hi=0x00000000, lo=0x0000002A at cycle E0+32.
- mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div 100/7 -> lo=14, hi=2. Then div 5/0 -> done and divzero pulse 1 cycle after E0, hi=5, lo=0xFFFFFFFF.
- Start mult 3*3, then hold mfhlD=10 from cycle E0+2:
  - stallhl=1 through cycle E0+31 and 0 in FIN.
  - hi=0, lo=9.
  - startE held during RUN does not restart; it is accepted in FIN, and busy returns the next cycle.
- Reset asserted at E0+10 of div 1000/3 -> IDLE next cycle, hi=lo=0, no done pulse. With MULDIV_SIGNED_EN: div -7/2 signed -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
